reset_seq: RTL and testbench
============================

# reset_seq

Parametrised reset controller that turns an asynchronous active-low board reset, a raw push-button and a synchronous software-reset request into `N_OUT` active-low domain resets. Assertion on `i_rst` is immediate on all outputs. Deassertion is synchronised, debounced and released in order with a programmable spacing, so downstream blocks (bus, CPU core, peripherals) leave reset in a defined sequence. It sits at the top level, directly behind the board reset and clock, and feeds every other block's reset input.

## Interface
- `SYNC_STAGES`, 2: flops in the `i_rst` release synchroniser and the button synchroniser; legal range ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed before the debounced button changes; legal range ≥1.
- `N_OUT`, 3: number of sequenced reset outputs; legal range ≥1.
- `STEP_CYCLES`, 2: cycles between release of `o_rst[k]` and `o_rst[k+1]`; legal range ≥1.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_btn`  in  1  raw reset button, active-low (pressed = 0), asynchronous to `i_clk`.
- `i_sw_rst`  in  1  software reset request, synchronous, active-high, 1-cycle pulse or level.
- `o_rst`  out  N_OUT  domain resets, active-low; bit 0 released first.
- `o_ready`  out  1  high when every `o_rst` bit is released.

## Operation
- `i_rst` low, asynchronous: all state is cleared. `o_rst` = all 0, `o_ready` = 0, the sync chain = 0, the button synchroniser = 1, the debounced button = 1 (released), FSM = HOLD, and all counters = 0.
- Release synchroniser: `SYNC_STAGES` flops, asynchronously cleared, that shift in 1. Its output is `rst_sync_n`.
- Button path: `SYNC_STAGES` synchroniser, then a counter.
  - The counter increments while the synced value ≠ the debounced value and clears otherwise.
  - When it reaches `DEBOUNCE_CYCLES`, the debounced value flips and the counter clears.
- FSM has three states.
  - HOLD: `o_rst` = 0. It moves to SEQ when `rst_sync_n`=1, the debounced button =1 and `i_sw_rst`=0. On that edge `o_rst[0]` goes to 1 and the step counter clears.
  - SEQ: the step counter counts to `STEP_CYCLES`. On each wrap the next `o_rst` bit goes to 1. The edge that releases `o_rst[N_OUT-1]` also moves to RUN and sets `o_ready`=1. With `N_OUT`=1, HOLD goes directly to RUN and `o_ready` rises with `o_rst[0]`.
  - RUN: all outputs are released.
- From SEQ or RUN, either a debounced press (value 0) or `i_sw_rst`=1 sends the FSM to HOLD. On the next edge `o_rst` becomes all 0 at once, `o_ready` becomes 0 and the step counter clears.
- Both requests in the same cycle behave the same as either one alone.
- A button held at power-up keeps the block in HOLD. It is detected after `SYNC_STAGES`+`DEBOUNCE_CYCLES` edges.
- The counter widths are `$clog2(MAX+1)`. Counters saturate and never wrap.

## Timing
- Assertion by `i_rst`: combinational/asynchronous, with zero clock latency.
- Assertion by button: a press stable from edge 0 is debounced at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. `o_rst` goes to 0 one edge later.
- Assertion by `i_sw_rst`: `o_rst` goes to 0 on the edge that samples it high.
- Release after `i_rst` rises, counting edges from 1 with the button released:
  - `rst_sync_n` goes to 1 at edge `SYNC_STAGES`.
  - `o_rst[0]` goes to 1 at edge `SYNC_STAGES`+1.
  - `o_rst[k]` goes to 1 at edge `SYNC_STAGES`+1+k·`STEP_CYCLES`.
  - `o_ready` rises together with `o_rst[N_OUT-1]`.
  - With the defaults, the releases fall on edges 3, 5 and 7.
- A new reset request during SEQ aborts the sequence. Every already-released bit returns to 0 on the next edge, and the sequence restarts from bit 0.
- `i_rst` glitch shorter than one cycle: the outputs still assert, and the full release sequence repeats.
- The outputs are registered, so there are no combinational paths from `i_btn` or `i_sw_rst` to `o_rst`.

## Structure
- `reset_seq_pkg` holds:
  - the FSM state encoding localparams (HOLD, SEQ, RUN);
  - the default parameter values;
  - the parameter legality checks, done as elaboration-time errors.
- Sub-module `rst_debounce`, holding the button synchroniser and the counter and parametrised by `SYNC_STAGES` and `DEBOUNCE_CYCLES`.
  - The release synchroniser, the FSM and the step counter stay in `reset_seq`.

## Test plan
- Power-up (defaults): `i_rst`=0 for 5 cycles, then 1, button high. Required: `o_rst`=000 throughout reset, then 001 at edge 3, 011 at edge 5, 111 and `o_ready`=1 at edge 7.
- Asynchronous assert in RUN: drop `i_rst` mid-cycle. Required: `o_rst`=000 and `o_ready`=0 before the next clock edge, then the full release sequence again after `i_rst` rises.
- Button debounce: in RUN, apply a 3-cycle low glitch on `i_btn`, then a 10-cycle press.
  - The glitch has no effect.
  - The press gives `o_rst`=000 at edge 7 after the press starts (2+4+1).
  - The release sequence begins 2+4 edges after the button release, with `o_rst[0]` one edge later.
- Software reset mid-sequence: pulse `i_sw_rst` for 1 cycle when `o_rst`=011. Required: 000 on that edge, then 001 on the next edge, and so on.
- Parameter sweep: `N_OUT`=1, `STEP_CYCLES`=1; `N_OUT`=5, `STEP_CYCLES`=3, `SYNC_STAGES`=3. Required: release edges match `SYNC_STAGES`+1+k·`STEP_CYCLES` exactly.
- Simultaneous button press and `i_sw_rst` in RUN: a single clean assertion, with no extra SEQ entry before both requests clear.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, parameter defaults
// and the legality rule applied at elaboration.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SEQ  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_N_OUT           = 3;
    localparam int DEF_STEP_CYCLES     = 2;

    function automatic bit params_legal(input int sync_stages, input int debounce_cycles,
                                        input int n_out, input int step_cycles);
        return (sync_stages >= 2) && (debounce_cycles >= 1) &&
               (n_out >= 1) && (step_cycles >= 1);
    endfunction

endpackage

// File: rtl/reset_seq_debounce.sv
// Button path: synchroniser into the clock domain, then a stability counter
// that only lets the debounced level change after a long enough steady run.
module rst_debounce
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // Reset to 1 so a released button is seen as released from the start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            btn_db <= 1'b1;
        end else if (synced == btn_db) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= synced;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reset_seq.sv
// Top-level reset controller: immediate assertion on the board reset, ordered
// and spaced release of the domain resets once every request source is quiet.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int N_OUT           = DEF_N_OUT,
    parameter int STEP_CYCLES     = DEF_STEP_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn,
    input  logic             i_sw_rst,
    output logic [N_OUT-1:0] o_rst,
    output logic             o_ready
);

    if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES, N_OUT, STEP_CYCLES)) begin : g_bad_params
        $error("reset_seq: illegal parameter combination");
    end

    localparam int SW = $clog2(STEP_CYCLES + 1);

    logic [SYNC_STAGES-1:0] rst_chain;
    logic                   rst_sync_n;
    logic                   btn_db;
    logic                   abort;

    state_t           state, state_nxt;
    logic [N_OUT-1:0] rst_nxt, rst_shift;
    logic             ready_nxt;
    logic [SW-1:0]    step_cnt, step_nxt;

    rst_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (i_clk),
        .rst_n (i_rst),
        .btn   (i_btn),
        .btn_db(btn_db)
    );

    // Asserts asynchronously, releases only after shifting 1s through the chain.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rst_chain <= '0;
        end else begin
            rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = rst_chain[SYNC_STAGES-1];
    assign abort      = !btn_db || i_sw_rst;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= HOLD;
            o_rst    <= '0;
            o_ready  <= 1'b0;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            o_rst    <= rst_nxt;
            o_ready  <= ready_nxt;
            step_cnt <= step_nxt;
        end
    end

    // Releasing shifts a 1 in at bit 0, so bits leave reset lowest first.
    always_comb begin
        state_nxt = state;
        rst_nxt   = o_rst;
        ready_nxt = o_ready;
        step_nxt  = step_cnt;
        rst_shift = N_OUT'({o_rst, 1'b1});
        unique case (state)
            HOLD: begin
                rst_nxt   = '0;
                ready_nxt = 1'b0;
                step_nxt  = '0;
                if (rst_sync_n && !abort) begin
                    rst_nxt   = N_OUT'(1);
                    ready_nxt = (N_OUT == 1);
                    state_nxt = (N_OUT == 1) ? RUN : SEQ;
                end
            end
            SEQ: begin
                if (abort) begin
                    state_nxt = HOLD;
                    rst_nxt   = '0;
                    ready_nxt = 1'b0;
                    step_nxt  = '0;
                end else if (step_cnt == SW'(STEP_CYCLES - 1)) begin
                    rst_nxt  = rst_shift;
                    step_nxt = '0;
                    if (&rst_shift) begin
                        state_nxt = RUN;
                        ready_nxt = 1'b1;
                    end
                end else begin
                    step_nxt = step_cnt + SW'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = HOLD;
                    rst_nxt   = '0;
                    ready_nxt = 1'b0;
                    step_nxt  = '0;
                end
            end
            default: begin
                state_nxt = HOLD;
                rst_nxt   = '0;
                ready_nxt = 1'b0;
                step_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: three instances (defaults and two parameter
// sweeps) share the stimulus; release edges are predicted from edge counts.
module tb_reset_seq;

    localparam int S0 = 2, N0 = 3, ST0 = 2;
    localparam int S1 = 2, N1 = 1, ST1 = 1;
    localparam int S2 = 3, N2 = 5, ST2 = 3;
    localparam int DEB = 4;

    localparam logic [2:0] PWR_TABLE [0:7] =
        '{3'b000, 3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111, 3'b111};

    logic          clk;
    logic          i_rst;
    logic          i_btn;
    logic          i_sw_rst;
    logic [N0-1:0] o_rst0;
    logic [N1-1:0] o_rst1;
    logic [N2-1:0] o_rst2;
    logic          o_ready0, o_ready1, o_ready2;

    int n_checks = 0;
    int n_fail   = 0;

    reset_seq dut0 (
        .i_clk(clk), .i_rst(i_rst), .i_btn(i_btn), .i_sw_rst(i_sw_rst),
        .o_rst(o_rst0), .o_ready(o_ready0)
    );

    reset_seq #(.N_OUT(N1), .STEP_CYCLES(ST1)) dut1 (
        .i_clk(clk), .i_rst(i_rst), .i_btn(i_btn), .i_sw_rst(i_sw_rst),
        .o_rst(o_rst1), .o_ready(o_ready1)
    );

    reset_seq #(.SYNC_STAGES(S2), .N_OUT(N2), .STEP_CYCLES(ST2)) dut2 (
        .i_clk(clk), .i_rst(i_rst), .i_btn(i_btn), .i_sw_rst(i_sw_rst),
        .o_rst(o_rst2), .o_ready(o_ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Bit k is released once edge e reaches s+1+k*step.
    function automatic logic [31:0] exp_rst(input int e, input int s, input int step, input int n);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++)
            if (e >= s + 1 + k * step) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] exp_ready(input int e, input int s, input int step, input int n);
        return {31'b0, (e >= s + 1 + (n - 1) * step)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag, input int e, input int add, input bit with_sync);
        int s0, s1, s2;
        s0 = (with_sync ? S0 : 0) + add;
        s1 = (with_sync ? S1 : 0) + add;
        s2 = (with_sync ? S2 : 0) + add;
        checkOutput($sformatf("%s dut0 o_rst e%0d", tag, e), 32'(o_rst0), exp_rst(e, s0, ST0, N0));
        checkOutput($sformatf("%s dut0 o_ready e%0d", tag, e), 32'(o_ready0), exp_ready(e, s0, ST0, N0));
        checkOutput($sformatf("%s dut1 o_rst e%0d", tag, e), 32'(o_rst1), exp_rst(e, s1, ST1, N1));
        checkOutput($sformatf("%s dut1 o_ready e%0d", tag, e), 32'(o_ready1), exp_ready(e, s1, ST1, N1));
        checkOutput($sformatf("%s dut2 o_rst e%0d", tag, e), 32'(o_rst2), exp_rst(e, s2, ST2, N2));
        checkOutput($sformatf("%s dut2 o_ready e%0d", tag, e), 32'(o_ready2), exp_ready(e, s2, ST2, N2));
    endtask

    task automatic run_seq(input string tag, input int first, input int last,
                           input int add, input bit with_sync);
        for (int e = first; e <= last; e++) begin
            tick();
            check_seq(tag, e, add, with_sync);
        end
    endtask

    task automatic check_level(input string tag, input bit released);
        checkOutput({tag, " dut0 o_rst"}, 32'(o_rst0), released ? 32'h7 : 32'h0);
        checkOutput({tag, " dut0 o_ready"}, 32'(o_ready0), {31'b0, released});
        checkOutput({tag, " dut1 o_rst"}, 32'(o_rst1), released ? 32'h1 : 32'h0);
        checkOutput({tag, " dut1 o_ready"}, 32'(o_ready1), {31'b0, released});
        checkOutput({tag, " dut2 o_rst"}, 32'(o_rst2), released ? 32'h1f : 32'h0);
        checkOutput({tag, " dut2 o_ready"}, 32'(o_ready2), {31'b0, released});
    endtask

    task automatic applyStimulus();
        // Power-up: reset held for five edges, then ordered release.
        i_rst    = 1'b0;
        i_btn    = 1'b1;
        i_sw_rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check_level($sformatf("in reset e%0d", e), 1'b0);
        end
        i_rst = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e <= 8) checkOutput($sformatf("pwr table e%0d", e), 32'(o_rst0), 32'(PWR_TABLE[e-1]));
            check_seq("pwr", e, 0, 1'b1);
        end

        // Asynchronous assert mid-cycle while running.
        #3 i_rst = 1'b0;
        #1 check_level("async assert", 1'b0);
        tick();
        check_level("async held", 1'b0);
        i_rst = 1'b1;
        run_seq("async rel", 1, 18, 0, 1'b1);

        // Sub-cycle glitch on i_rst still restarts the whole sequence.
        #3 i_rst = 1'b0;
        #1 check_level("glitch assert", 1'b0);
        #2 i_rst = 1'b1;
        #1 check_level("glitch after", 1'b0);
        run_seq("glitch rel", 1, 18, 0, 1'b1);

        // Short button glitch is filtered.
        i_btn = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_level($sformatf("btn glitch e%0d", e), 1'b1);
        end
        i_btn = 1'b1;
        for (int e = 4; e <= 11; e++) begin
            tick();
            check_level($sformatf("btn glitch e%0d", e), 1'b1);
        end

        // Ten-cycle press: asserted at S+DEB+1, released S+DEB edges after release.
        i_btn = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checkOutput($sformatf("press dut0 e%0d", e), 32'(o_rst0), (e >= S0 + DEB + 1) ? 32'h0 : 32'h7);
            checkOutput($sformatf("press dut1 e%0d", e), 32'(o_rst1), (e >= S1 + DEB + 1) ? 32'h0 : 32'h1);
            checkOutput($sformatf("press dut2 e%0d", e), 32'(o_rst2), (e >= S2 + DEB + 1) ? 32'h0 : 32'h1f);
        end
        i_btn = 1'b1;
        run_seq("btn rel", 1, 22, DEB, 1'b1);

        // Software reset when dut0 shows 011.
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        run_seq("sw pre", 1, 5, 0, 1'b1);
        checkOutput("sw at 011", 32'(o_rst0), 32'h3);
        i_sw_rst = 1'b1;
        tick();
        i_sw_rst = 1'b0;
        check_seq("sw", 1, 1, 1'b0);
        run_seq("sw", 2, 16, 1, 1'b0);

        // Press and software reset together: one assertion, held until both clear.
        i_btn    = 1'b0;
        i_sw_rst = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check_level($sformatf("both e%0d", e), 1'b0);
            if (e == 8) i_sw_rst = 1'b0;
        end
        i_btn = 1'b1;
        run_seq("both rel", 1, 22, DEB, 1'b1);
    endtask

    initial begin
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
